// File: rtl/policy_cfg_loader.sv
// Copies policy entries from a local table into APB configuration registers,
// verifying every write with a readback, then commits (locks) the policy set.
module policy_cfg_loader #(
  parameter int unsigned NUM_POLICY    = 8,
  parameter logic [31:0] CFG_BASE      = 32'h4001_0000,
  parameter int unsigned POLICY_STRIDE = 16,
  localparam int unsigned AW           = $clog2(NUM_POLICY * 4)
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          start,
  input  logic [3:0]    num_policy,
  output logic          tbl_rd,
  output logic [AW-1:0] tbl_addr,
  input  logic [31:0]   tbl_rdata,
  output logic          PSEL,
  output logic          PENABLE,
  output logic          PWRITE,
  output logic [31:0]   PADDR,
  output logic [31:0]   PWDATA,
  input  logic [31:0]   PRDATA,
  input  logic          PREADY,
  input  logic          PSLVERR,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [3:0]    err_idx,
  output logic          lock
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StCapt, StWsetup, StWaccess, StRsetup, StRaccess, StDone
  } state_e;

  state_e      state_q;
  logic [3:0]  entry_q;
  logic [1:0]  word_q;
  logic [3:0]  cnt_q;

  logic [3:0]  clamped;
  logic [31:0] paddr_calc;
  logic        last_word;
  logic [3:0]  next_entry;
  logic [1:0]  next_word;
  logic        wr_fail;
  logic        rd_fail;

  always_comb begin
    clamped    = (32'(num_policy) > NUM_POLICY) ? 4'(NUM_POLICY) : num_policy;
    paddr_calc = CFG_BASE + 32'(POLICY_STRIDE) * {28'd0, entry_q} + {28'd0, word_q, 2'b00};
    last_word  = (word_q == 2'd3) && ((entry_q + 4'd1) == cnt_q);
    next_word  = word_q + 2'd1;
    next_entry = (word_q == 2'd3) ? entry_q + 4'd1 : entry_q;
    wr_fail    = PREADY && PSLVERR;
    // Readback must match the full written word, not just the implemented bits.
    rd_fail    = PREADY && (PSLVERR || (PRDATA != PWDATA));
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= StIdle;
      entry_q  <= '0;
      word_q   <= '0;
      cnt_q    <= '0;
      tbl_rd   <= 1'b0;
      tbl_addr <= '0;
      PSEL     <= 1'b0;
      PENABLE  <= 1'b0;
      PWRITE   <= 1'b0;
      PADDR    <= '0;
      PWDATA   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_idx  <= '0;
      lock     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start && !lock) begin
            cnt_q <= clamped;
            busy  <= 1'b1;
            if (clamped == 4'd0) begin
              done    <= 1'b1;
              state_q <= StDone;
            end else begin
              err      <= 1'b0;
              entry_q  <= '0;
              word_q   <= '0;
              tbl_addr <= '0;
              tbl_rd   <= 1'b1;
              state_q  <= StFetch;
            end
          end
        end
        StFetch: begin
          tbl_rd  <= 1'b0;
          state_q <= StCapt;
        end
        StCapt: begin
          PWDATA  <= tbl_rdata;
          PADDR   <= paddr_calc;
          PSEL    <= 1'b1;
          PWRITE  <= 1'b1;
          state_q <= StWsetup;
        end
        StWsetup: begin
          PENABLE <= 1'b1;
          state_q <= StWaccess;
        end
        StWaccess: begin
          if (wr_fail) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            err     <= 1'b1;
            err_idx <= entry_q;
            done    <= 1'b1;
            state_q <= StDone;
          end else if (PREADY) begin
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            state_q <= StRsetup;
          end
        end
        StRsetup: begin
          PENABLE <= 1'b1;
          state_q <= StRaccess;
        end
        StRaccess: begin
          if (PREADY) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            if (rd_fail) begin
              err     <= 1'b1;
              err_idx <= entry_q;
              done    <= 1'b1;
              state_q <= StDone;
            end else if (last_word) begin
              done    <= 1'b1;
              state_q <= StDone;
            end else begin
              entry_q  <= next_entry;
              word_q   <= next_word;
              tbl_addr <= AW'({next_entry, next_word});
              tbl_rd   <= 1'b1;
              state_q  <= StFetch;
            end
          end
        end
        StDone: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          // An empty load completes but never commits the policy set.
          if (!err && (cnt_q != 4'd0)) lock <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_policy_cfg_loader.sv
// Directed bench for policy_cfg_loader: APB slave/table responder plus a write
// scoreboard fed when each load is started.
module tb_policy_cfg_loader;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  num_policy = 4'd0;
  logic        tbl_rd;
  logic [4:0]  tbl_addr;
  logic [31:0] tbl_rdata = 32'h0;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [31:0] PRDATA = 32'h0;
  logic        PREADY = 1'b1;
  logic        PSLVERR = 1'b0;
  logic        busy, done, err, lock;
  logic [3:0]  err_idx;

  int tests = 0;
  int fails = 0;

  logic [31:0] tbl [32];
  logic [31:0] exp_addr [$];
  logic [31:0] exp_data [$];
  logic [31:0] mem [logic [31:0]];
  int          wait_cfg = 0;
  int          wait_cnt = 0;
  int          wr_count = 0;
  logic [31:0] slverr_addr = 32'hFFFF_FFFF;
  logic [31:0] corrupt_addr = 32'hFFFF_FFFF;
  logic [31:0] hold_addr, hold_data;
  logic        rd_seen = 1'b0;
  logic [4:0]  addr_seen = 5'd0;
  logic        err_after_start;

  policy_cfg_loader dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .start     (start),
    .num_policy(num_policy),
    .tbl_rd    (tbl_rd),
    .tbl_addr  (tbl_addr),
    .tbl_rdata (tbl_rdata),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_idx   (err_idx),
    .lock      (lock)
  );

  initial forever #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Table and APB slave responder; all inputs change on the falling edge.
  initial begin
    logic [31:0] ea, ed;
    forever begin
      @(negedge HCLK);
      tbl_rdata = rd_seen ? tbl[addr_seen] : 32'hDEAD_BEEF;
      rd_seen   = tbl_rd;
      addr_seen = tbl_addr;
      if (PSEL && PENABLE) begin
        if (PWRITE && wait_cnt > 0) begin
          chk("wait_paddr_stable", PADDR, hold_addr);
          chk("wait_pwdata_stable", PWDATA, hold_data);
        end
        if (PWRITE && wait_cnt < wait_cfg) begin
          if (wait_cnt == 0) begin
            hold_addr = PADDR;
            hold_data = PWDATA;
          end
          PREADY = 1'b0;
          wait_cnt++;
        end else begin
          PREADY = 1'b1;
        end
      end else begin
        wait_cnt = 0;
        PREADY   = 1'b1;
      end
      PSLVERR = PSEL && PENABLE && PWRITE && (PADDR == slverr_addr);
      PRDATA  = (PADDR == corrupt_addr) ? 32'h0BAD_BEEF :
                (mem.exists(PADDR) ? mem[PADDR] : 32'h0);
      if (PSEL && PENABLE && PREADY && PWRITE) begin
        tests++;
        assert (exp_addr.size() != 0) else begin
          fails++;
          $error("FAIL unexpected_write observed addr=%h expected no write", PADDR);
        end
        if (exp_addr.size() != 0) begin
          ea = exp_addr.pop_front();
          ed = exp_data.pop_front();
          chk("wr_addr", PADDR, ea);
          chk("wr_data", PWDATA, ed);
        end
        mem[PADDR] = PWDATA;
        wr_count++;
      end
    end
  end

  task automatic push_words(input int nw);
    for (int w = 0; w < nw; w++) begin
      exp_addr.push_back(32'h4001_0000 + 32'(w) * 32'd4);
      exp_data.push_back(tbl[w]);
    end
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    start   = 1'b0;
    @(negedge HCLK);
    @(negedge HCLK);
    exp_addr.delete();
    exp_data.delete();
    mem.delete();
    wait_cfg     = 0;
    slverr_addr  = 32'hFFFF_FFFF;
    corrupt_addr = 32'hFFFF_FFFF;
    wr_count     = 0;
    HRESETn      = 1'b1;
    @(negedge HCLK);
  endtask

  // Cycle 0 is the edge that accepts start; returns the cycle done is seen, -1 on timeout.
  task automatic run_load(input logic [3:0] n, output int cycles);
    @(negedge HCLK);
    start      = 1'b1;
    num_policy = n;
    @(posedge HCLK);
    #1;
    start           = 1'b0;
    err_after_start = err;
    cycles          = 0;
    do begin
      @(negedge HCLK);
      cycles++;
    end while (!done && cycles < 1000);
    if (!done) cycles = -1;
  endtask

  initial begin
    int c;
    int k;
    int wr_before;
    logic seen;

    tbl[0] = 32'h0000_0002; tbl[1] = 32'h2000_0000;
    tbl[2] = 32'h0001_FFFF; tbl[3] = 32'h0000_0003;
    tbl[4] = 32'h0000_0003; tbl[5] = 32'h2000_0000;
    tbl[6] = 32'h0001_FFFF; tbl[7] = 32'h0000_0003;
    for (int i = 8; i < 32; i++) tbl[i] = 32'hA500_0000 + 32'(i) * 32'h0001_0101;

    do_reset();
    chk("rst_ctrl", 32'({busy, done, err, lock, PSEL, PENABLE, PWRITE, tbl_rd}), 32'h0);
    chk("rst_paddr", PADDR, 32'h0);
    chk("rst_pwdata", PWDATA, 32'h0);
    chk("rst_addr_idx", 32'({tbl_addr, err_idx}), 32'h0);

    // Empty load: immediate done, no lock.
    run_load(4'd0, c);
    chk("n0_done_cycle", 32'(c), 32'd1);
    @(negedge HCLK);
    chk("n0_after", 32'({busy, done, err, lock}), 32'h0);
    chk("n0_writes", 32'(wr_count), 32'd0);

    // Two entries, zero-wait slave.
    push_words(8);
    run_load(4'd2, c);
    chk("n2_done_cycle", 32'(c), 32'd49);
    chk("n2_err", 32'(err), 32'd0);
    @(negedge HCLK);
    chk("n2_lock", 32'(lock), 32'd1);
    chk("n2_idle", 32'({busy, done}), 32'h0);
    chk("n2_queue_empty", 32'(exp_addr.size()), 32'd0);
    chk("n2_writes", 32'(wr_count), 32'd8);

    // Locked: start must be ignored.
    wr_before = wr_count;
    @(negedge HCLK);
    start      = 1'b1;
    num_policy = 4'd4;
    @(posedge HCLK);
    #1;
    start = 1'b0;
    seen  = 1'b0;
    repeat (30) begin
      @(negedge HCLK);
      seen = seen | busy | PSEL | done | tbl_rd;
    end
    chk("locked_quiet", 32'(seen), 32'd0);
    chk("locked_writes", 32'(wr_count), 32'(wr_before));

    // Wait states on every write access.
    do_reset();
    chk("rst_clears_lock", 32'(lock), 32'd0);
    wait_cfg = 3;
    push_words(4);
    run_load(4'd1, c);
    chk("wait_done_cycle", 32'(c), 32'd37);
    @(negedge HCLK);
    chk("wait_lock", 32'(lock), 32'd1);
    chk("wait_queue_empty", 32'(exp_addr.size()), 32'd0);

    // Slave error on entry 1 word 2.
    do_reset();
    slverr_addr = 32'h4001_0018;
    push_words(7);
    run_load(4'd3, c);
    chk("slverr_done_cycle", 32'(c), 32'd41);
    chk("slverr_err", 32'(err), 32'd1);
    chk("slverr_idx", 32'(err_idx), 32'd1);
    @(negedge HCLK);
    chk("slverr_lock", 32'(lock), 32'd0);
    chk("slverr_queue_empty", 32'(exp_addr.size()), 32'd0);
    slverr_addr = 32'hFFFF_FFFF;

    // Readback mismatch on the 0001FFFF word, then a clean reload.
    corrupt_addr = 32'h4001_0008;
    push_words(3);
    run_load(4'd1, c);
    chk("mism_done_cycle", 32'(c), 32'd19);
    chk("mism_err", 32'(err), 32'd1);
    chk("mism_idx", 32'(err_idx), 32'd0);
    @(negedge HCLK);
    chk("mism_lock", 32'(lock), 32'd0);
    chk("mism_queue_empty", 32'(exp_addr.size()), 32'd0);
    corrupt_addr = 32'hFFFF_FFFF;
    push_words(4);
    run_load(4'd1, c);
    chk("reload_err_cleared", 32'(err_after_start), 32'd0);
    chk("reload_done_cycle", 32'(c), 32'd25);
    chk("reload_err", 32'(err), 32'd0);
    @(negedge HCLK);
    chk("reload_lock", 32'(lock), 32'd1);

    // Oversized request is clamped to the table size.
    do_reset();
    push_words(32);
    run_load(4'd12, c);
    chk("clamp_done_cycle", 32'(c), 32'd193);
    @(negedge HCLK);
    chk("clamp_lock", 32'(lock), 32'd1);
    chk("clamp_writes", 32'(wr_count), 32'd32);

    // Reset in the middle of a write access, then restart from entry 0.
    do_reset();
    wait_cfg = 3;
    push_words(8);
    @(negedge HCLK);
    start      = 1'b1;
    num_policy = 4'd2;
    @(posedge HCLK);
    #1;
    start = 1'b0;
    k     = 0;
    while (!(PSEL && PENABLE && PWRITE) && k < 100) begin
      @(negedge HCLK);
      k++;
    end
    chk("arst_reached_waccess", 32'({PSEL, PENABLE, PWRITE}), 32'h7);
    #1;
    HRESETn = 1'b0;
    #1;
    chk("arst_apb_idle", 32'({PSEL, PENABLE, busy, lock}), 32'h0);
    chk("arst_paddr", PADDR, 32'h0);
    do_reset();
    push_words(4);
    run_load(4'd1, c);
    chk("restart_done_cycle", 32'(c), 32'd25);
    chk("restart_queue_empty", 32'(exp_addr.size()), 32'd0);
    chk("restart_writes", 32'(wr_count), 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
